// File: rtl/fft_integ_pkg.sv
// Shared types and helpers for the post-FFT non-coherent peak integrator.
//   state_e  : integrator control states
//   clog2    : constant ceil(log2(v)) used to size bin indices
//   sat_add  : unsigned add clamped to a w-bit maximum; the MSB of the
//              result flags that the clamp was applied
package fft_integ_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTEG = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Widest accumulator the saturating adder supports.
  localparam int unsigned SAT_MAXW = 96;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [SAT_MAXW:0] sat_add(input logic [SAT_MAXW-1:0] a,
                                                input logic [SAT_MAXW-1:0] b,
                                                input int unsigned         w);
    logic [SAT_MAXW:0] s;
    logic [SAT_MAXW:0] one;
    logic [SAT_MAXW:0] lim;
    one = {{SAT_MAXW{1'b0}}, 1'b1};
    s   = {1'b0, a} + {1'b0, b};
    lim = (one << w) - one;
    if (s > lim) return lim | {1'b1, {SAT_MAXW{1'b0}}};
    return s;
  endfunction

endpackage

// File: rtl/fft_peak_integrator_if.sv
// Stream/result bundle of the peak integrator.
//   START, NUM_FRAMES             : run control from the host
//   DATAI_RE/IM, DATAI_VALID      : FFT output stream, bins in order
//   BUSY                          : run in progress
//   RESULT_VALID/READY            : result handshake
//   PEAK_BIN, PEAK_VAL, SAT_FLAG  : result payload
//   NOISE_SUM                     : sum of all final bins (FFT_PEAK_NOISE_EN)
// master: host/FFT side; slave: integrator side.
interface fft_peak_integrator_if #(
  parameter int POINTS = 1024,
  parameter int IN_W   = 32,
  parameter int ACC_W  = 40,
  parameter int NF_W   = 8
);
  import fft_integ_pkg::*;

  localparam int AW = clog2(POINTS);

  logic                   START;
  logic [NF_W-1:0]        NUM_FRAMES;
  logic signed [IN_W-1:0] DATAI_RE;
  logic signed [IN_W-1:0] DATAI_IM;
  logic                   DATAI_VALID;
  logic                   BUSY;
  logic                   RESULT_VALID;
  logic                   RESULT_READY;
  logic [AW-1:0]          PEAK_BIN;
  logic [ACC_W-1:0]       PEAK_VAL;
  logic                   SAT_FLAG;
`ifdef FFT_PEAK_NOISE_EN
  logic [ACC_W+AW-1:0]    NOISE_SUM;

  modport master (output START, NUM_FRAMES, DATAI_RE, DATAI_IM, DATAI_VALID, RESULT_READY,
                  input  BUSY, RESULT_VALID, PEAK_BIN, PEAK_VAL, SAT_FLAG, NOISE_SUM);
  modport slave  (input  START, NUM_FRAMES, DATAI_RE, DATAI_IM, DATAI_VALID, RESULT_READY,
                  output BUSY, RESULT_VALID, PEAK_BIN, PEAK_VAL, SAT_FLAG, NOISE_SUM);
`else
  modport master (output START, NUM_FRAMES, DATAI_RE, DATAI_IM, DATAI_VALID, RESULT_READY,
                  input  BUSY, RESULT_VALID, PEAK_BIN, PEAK_VAL, SAT_FLAG);
  modport slave  (input  START, NUM_FRAMES, DATAI_RE, DATAI_IM, DATAI_VALID, RESULT_READY,
                  output BUSY, RESULT_VALID, PEAK_BIN, PEAK_VAL, SAT_FLAG);
`endif
endinterface

// File: rtl/fft_integ_ram.sv
// Simple dual-port accumulator RAM, one write and one read port, registered
// read (data appears the cycle after the address).
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   raddr_i/rdata_o  : read port
module fft_integ_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 40,
  parameter int AW    = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fft_peak_integrator.sv
// Post-FFT non-coherent integrator: accumulates |X|^2 per bin over a
// programmable number of frames and reports the strongest bin.
//   CLK, NGRST : clock, asynchronous active-low reset
//   bus        : fft_peak_integrator_if.slave (stream in, result out)
// Optional build macro FFT_PEAK_NOISE_EN adds NOISE_SUM, the sum of all
// final accumulated bins of the run.
module fft_peak_integrator
  import fft_integ_pkg::*;
#(
  parameter int POINTS    = 1024,
  parameter int IN_W      = 32,
  parameter int MAG_SHIFT = 32,
  parameter int ACC_W     = 40,
  parameter int NF_W      = 8
) (
  input  logic CLK,
  input  logic NGRST,
  fft_peak_integrator_if.slave bus
);
  localparam int AW    = clog2(POINTS);
  localparam int PW    = 2 * IN_W;
  localparam int SUM_W = PW + 1;

  // Scale the power and clamp anything that does not fit the accumulator.
  function automatic logic [ACC_W-1:0] clamp_pow(input logic [SUM_W-1:0] pw);
    logic [SUM_W+ACC_W-1:0] ext;
    ext = {{ACC_W{1'b0}}, pw} >> MAG_SHIFT;
    if ((ext >> ACC_W) != '0) return '1;
    return ext[ACC_W-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [NF_W-1:0]  nf_q, frame_cnt_q;
  logic [AW-1:0]    bin_cnt_q;
  logic             sat_q, vld_p1_q, vld_p2_q;
  logic [AW-1:0]    peak_bin_q, max_bin_q;
  logic [ACC_W-1:0] peak_val_q, max_val_q;
  logic             start_ok, accept, last_bin, last_frame, drained;

  logic signed [PW-1:0] re_x, im_x;
  logic [PW-1:0]        re2_p1_q, im2_p1_q;
  logic [AW-1:0]        bin_p1_q, bin_p2_q;
  logic                 f0_p1_q, f0_p2_q, lf_p1_q, lf_p2_q;
  logic [ACC_W-1:0]     sum_p2_q, rd_p2_q, rd_data, new_s3;
  logic [SAT_MAXW:0]    sa;
  logic                 ovf_s3;
`ifdef FFT_PEAK_NOISE_EN
  localparam int NS_W = ACC_W + AW;
  logic [NS_W-1:0] noise_acc_q, noise_q;
`endif

  assign start_ok   = (state_q == IDLE) && bus.START;
  assign accept     = (state_q == INTEG) && bus.DATAI_VALID;
  assign last_bin   = (bin_cnt_q == AW'(POINTS - 1));
  assign last_frame = (frame_cnt_q == nf_q - NF_W'(1));
  assign drained    = !vld_p1_q && !vld_p2_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.START) state_d = INTEG;
      INTEG:   if (accept && last_bin && last_frame) state_d = FLUSH;
      FLUSH:   if (drained) state_d = DONE;
      DONE:    if (bus.RESULT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      state_q     <= IDLE;
      nf_q        <= '0;
      frame_cnt_q <= '0;
      bin_cnt_q   <= '0;
      sat_q       <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      peak_bin_q  <= '0;
      peak_val_q  <= '0;
`ifdef FFT_PEAK_NOISE_EN
      noise_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      vld_p1_q <= accept;
      vld_p2_q <= vld_p1_q;
      if (start_ok) begin
        nf_q        <= (bus.NUM_FRAMES == '0) ? NF_W'(1) : bus.NUM_FRAMES;
        frame_cnt_q <= '0;
        bin_cnt_q   <= '0;
        sat_q       <= 1'b0;
      end
      if (accept) begin
        bin_cnt_q <= bin_cnt_q + AW'(1);
        if (last_bin) frame_cnt_q <= frame_cnt_q + NF_W'(1);
      end
      if (vld_p2_q && ovf_s3) sat_q <= 1'b1;
      // Capture the result as the last write retires.
      if ((state_q == FLUSH) && drained) begin
        peak_bin_q <= max_bin_q;
        peak_val_q <= max_val_q;
`ifdef FFT_PEAK_NOISE_EN
        noise_q    <= noise_acc_q;
`endif
      end
    end
  end

  assign re_x = PW'(bus.DATAI_RE);
  assign im_x = PW'(bus.DATAI_IM);

  // Frame 0 overwrites whatever the RAM holds, so no clear pass is needed.
  assign sa     = sat_add(SAT_MAXW'(rd_p2_q), SAT_MAXW'(sum_p2_q), ACC_W);
  assign new_s3 = f0_p2_q ? sum_p2_q : sa[ACC_W-1:0];
  assign ovf_s3 = !f0_p2_q && (sa[SAT_MAXW] || (|sa[SAT_MAXW-1:ACC_W]));

  always_ff @(posedge CLK) begin
    // S1: squares, RAM read issued for bin_cnt
    re2_p1_q <= $unsigned(re_x * re_x);
    im2_p1_q <= $unsigned(im_x * im_x);
    bin_p1_q <= bin_cnt_q;
    f0_p1_q  <= (frame_cnt_q == '0);
    lf_p1_q  <= last_frame;
    // S2: scaled power, RAM read data
    sum_p2_q <= clamp_pow(SUM_W'(re2_p1_q) + SUM_W'(im2_p1_q));
    rd_p2_q  <= rd_data;
    bin_p2_q <= bin_p1_q;
    f0_p2_q  <= f0_p1_q;
    lf_p2_q  <= lf_p1_q;
    // S3: accumulate/write back; peak search on the final frame
    if (vld_p2_q && lf_p2_q) begin
      // Strict compare keeps the lowest bin on ties.
      if ((bin_p2_q == '0) || (new_s3 > max_val_q)) begin
        max_val_q <= new_s3;
        max_bin_q <= bin_p2_q;
      end
`ifdef FFT_PEAK_NOISE_EN
      noise_acc_q <= (bin_p2_q == '0) ? NS_W'(new_s3) : noise_acc_q + NS_W'(new_s3);
`endif
    end
  end

  fft_integ_ram #(
    .DEPTH (POINTS),
    .WIDTH (ACC_W),
    .AW    (AW)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (vld_p2_q),
    .waddr_i (bin_p2_q),
    .wdata_i (new_s3),
    .raddr_i (bin_cnt_q),
    .rdata_o (rd_data)
  );

  assign bus.BUSY         = (state_q == INTEG) || (state_q == FLUSH);
  assign bus.RESULT_VALID = (state_q == DONE);
  assign bus.PEAK_BIN     = peak_bin_q;
  assign bus.PEAK_VAL     = peak_val_q;
  assign bus.SAT_FLAG     = sat_q;
`ifdef FFT_PEAK_NOISE_EN
  assign bus.NOISE_SUM    = noise_q;
`endif
endmodule

// File: tb/tb_fft_peak_integrator.sv
// Bench for fft_peak_integrator: 16-point, 8-bit samples, 8-bit accumulator.
// Expected results come from a per-bin array model of the integration rules.
module tb_fft_peak_integrator;
  localparam int POINTS    = 16;
  localparam int IN_W      = 8;
  localparam int MAG_SHIFT = 0;
  localparam int ACC_W     = 8;
  localparam int NF_W      = 4;
  localparam int AW        = 4;
  localparam int VMAX      = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic ngrst = 1'b0;
  always #5 clk = ~clk;

  int unsigned ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  int vec = 0;
  int err = 0;
  int q_re[$];
  int q_im[$];

  fft_peak_integrator_if #(.POINTS(POINTS), .IN_W(IN_W), .ACC_W(ACC_W), .NF_W(NF_W)) bus ();

  fft_peak_integrator #(
    .POINTS(POINTS), .IN_W(IN_W), .MAG_SHIFT(MAG_SHIFT), .ACC_W(ACC_W), .NF_W(NF_W)
  ) dut (
    .CLK   (clk),
    .NGRST (ngrst),
    .bus   (bus)
  );

  function automatic void model(input int nfr, output int pbin, output int pval,
                                output bit psat, output int pnoise);
    int acc [POINTS];
    int sq;
    psat = 1'b0;
    for (int f = 0; f < nfr; f++) begin
      for (int b = 0; b < POINTS; b++) begin
        sq = (q_re[f*POINTS+b] * q_re[f*POINTS+b] + q_im[f*POINTS+b] * q_im[f*POINTS+b]) >> MAG_SHIFT;
        if (sq > VMAX) sq = VMAX;
        if (f == 0) acc[b] = sq;
        else if (acc[b] + sq > VMAX) begin
          acc[b] = VMAX;
          psat = 1'b1;
        end else acc[b] = acc[b] + sq;
      end
    end
    pbin = 0;
    pval = acc[0];
    pnoise = 0;
    for (int b = 0; b < POINTS; b++) begin
      pnoise += acc[b];
      if (acc[b] > pval) begin
        pval = acc[b];
        pbin = b;
      end
    end
  endfunction

  task automatic fill_zero(input int nfr);
    q_re.delete();
    q_im.delete();
    repeat (nfr * POINTS) begin
      q_re.push_back(0);
      q_im.push_back(0);
    end
  endtask

  task automatic fill_rand(input int nfr);
    q_re.delete();
    q_im.delete();
    repeat (nfr * POINTS) begin
      if ($urandom_range(0, 9) == 0) begin
        q_re.push_back(int'($urandom_range(0, 255)) - 128);
        q_im.push_back(int'($urandom_range(0, 255)) - 128);
      end else begin
        q_re.push_back(int'($urandom_range(0, 16)) - 8);
        q_im.push_back(int'($urandom_range(0, 16)) - 8);
      end
    end
  endtask

  task automatic start_run(input int nfv);
    @(negedge clk);
    bus.NUM_FRAMES = NF_W'(nfv);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  task automatic drive(input int nfr, input int max_gap, input int start_at, output int last_k);
    last_k = 0;
    for (int i = 0; i < nfr * POINTS; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) begin
        @(negedge clk);
        bus.DATAI_VALID = 1'b0;
        bus.START = 1'b0;
      end
      @(negedge clk);
      bus.DATAI_VALID = 1'b1;
      bus.DATAI_RE = IN_W'(q_re[i]);
      bus.DATAI_IM = IN_W'(q_im[i]);
      bus.START = (i == start_at);
      if (i == start_at) bus.NUM_FRAMES = NF_W'(7);
      last_k = int'(ncyc);
    end
    @(negedge clk);
    bus.DATAI_VALID = 1'b0;
    bus.START = 1'b0;
  endtask

  task automatic wait_rv(input int last_k, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.RESULT_VALID === 1'b1) begin
        lat = int'(ncyc) - last_k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept_result();
    @(negedge clk);
    bus.RESULT_READY = 1'b1;
    @(negedge clk);
    bus.RESULT_READY = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vec += 5;
    if (bus.BUSY !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
    if (bus.RESULT_VALID !== 1'b0) begin err++; $display("FAIL reset_rv got %b want 0", bus.RESULT_VALID); end
    if (bus.PEAK_BIN !== '0) begin err++; $display("FAIL reset_bin got %0d want 0", bus.PEAK_BIN); end
    if (bus.PEAK_VAL !== '0) begin err++; $display("FAIL reset_val got %0d want 0", bus.PEAK_VAL); end
    if (bus.SAT_FLAG !== 1'b0) begin err++; $display("FAIL reset_sat got %b want 0", bus.SAT_FLAG); end
`ifdef FFT_PEAK_NOISE_EN
    vec++;
    if (bus.NOISE_SUM !== '0) begin err++; $display("FAIL reset_noise got %0d want 0", bus.NOISE_SUM); end
`endif
    @(negedge clk);
    ngrst = 1'b1;
  endtask

  task automatic test_single_peak();
    int k, lat;
    fill_zero(1);
    q_re[5] = 3;
    q_im[5] = 4;
    start_run(1);
    drive(1, 0, -1, k);
    wait_rv(k, lat);
    vec += 5;
    if (lat != 4) begin err++; $display("FAIL single_latency got %0d want 4", lat); end
    if (bus.BUSY !== 1'b0) begin err++; $display("FAIL single_busy got %b want 0", bus.BUSY); end
    if (bus.PEAK_BIN !== AW'(5)) begin err++; $display("FAIL single_bin got %0d want 5", bus.PEAK_BIN); end
    if (bus.PEAK_VAL !== ACC_W'(25)) begin err++; $display("FAIL single_val got %0d want 25", bus.PEAK_VAL); end
    if (bus.SAT_FLAG !== 1'b0) begin err++; $display("FAIL single_sat got %b want 0", bus.SAT_FLAG); end
`ifdef FFT_PEAK_NOISE_EN
    vec++;
    if (bus.NOISE_SUM !== (ACC_W+AW)'(25)) begin err++; $display("FAIL single_noise got %0d want 25", bus.NOISE_SUM); end
`endif
    accept_result();
    vec++;
    if (bus.RESULT_VALID !== 1'b0) begin err++; $display("FAIL single_rv_drop got %b want 0", bus.RESULT_VALID); end
  endtask

  task automatic test_gapped_frames();
    int k, lat;
    fill_zero(4);
    for (int f = 0; f < 4; f++) begin
      q_re[f*POINTS+9] = 1;
      q_im[f*POINTS+9] = 1;
    end
    start_run(4);
    drive(4, 3, -1, k);
    wait_rv(k, lat);
    vec += 4;
    if (lat != 4) begin err++; $display("FAIL gapped_latency got %0d want 4", lat); end
    if (bus.PEAK_BIN !== AW'(9)) begin err++; $display("FAIL gapped_bin got %0d want 9", bus.PEAK_BIN); end
    if (bus.PEAK_VAL !== ACC_W'(8)) begin err++; $display("FAIL gapped_val got %0d want 8", bus.PEAK_VAL); end
    if (bus.SAT_FLAG !== 1'b0) begin err++; $display("FAIL gapped_sat got %b want 0", bus.SAT_FLAG); end
    accept_result();
  endtask

  task automatic test_tie();
    int k, lat;
    fill_zero(1);
    q_re[2] = 2;
    q_re[7] = 2;
    start_run(1);
    drive(1, 1, -1, k);
    wait_rv(k, lat);
    vec += 2;
    if (bus.PEAK_BIN !== AW'(2)) begin err++; $display("FAIL tie_bin got %0d want 2", bus.PEAK_BIN); end
    if (bus.PEAK_VAL !== ACC_W'(4)) begin err++; $display("FAIL tie_val got %0d want 4", bus.PEAK_VAL); end
    accept_result();
  endtask

  task automatic test_saturate();
    int k, lat;
    fill_zero(3);
    for (int f = 0; f < 3; f++) q_re[f*POINTS+1] = 10;
    start_run(3);
    drive(3, 0, -1, k);
    wait_rv(k, lat);
    vec += 3;
    if (bus.PEAK_BIN !== AW'(1)) begin err++; $display("FAIL sat_bin got %0d want 1", bus.PEAK_BIN); end
    if (bus.PEAK_VAL !== ACC_W'(255)) begin err++; $display("FAIL sat_val got %0d want 255", bus.PEAK_VAL); end
    if (bus.SAT_FLAG !== 1'b1) begin err++; $display("FAIL sat_flag got %b want 1", bus.SAT_FLAG); end
    accept_result();
  endtask

  task automatic test_hold_restart();
    int k, lat, eb, ev, en;
    bit es;
    fill_rand(2);
    model(2, eb, ev, es, en);
    start_run(2);
    drive(2, 1, 10, k);
    wait_rv(k, lat);
    vec++;
    if (lat != 4) begin err++; $display("FAIL hold_latency got %0d want 4", lat); end
    for (int i = 0; i < 10; i++) begin
      vec += 4;
      if (bus.RESULT_VALID !== 1'b1) begin err++; $display("FAIL hold_rv cyc %0d got %b want 1", i, bus.RESULT_VALID); end
      if (bus.PEAK_BIN !== AW'(eb)) begin err++; $display("FAIL hold_bin cyc %0d got %0d want %0d", i, bus.PEAK_BIN, eb); end
      if (bus.PEAK_VAL !== ACC_W'(ev)) begin err++; $display("FAIL hold_val cyc %0d got %0d want %0d", i, bus.PEAK_VAL, ev); end
      if (bus.SAT_FLAG !== es) begin err++; $display("FAIL hold_sat cyc %0d got %b want %b", i, bus.SAT_FLAG, es); end
      @(negedge clk);
    end
    accept_result();
    vec += 2;
    if (bus.RESULT_VALID !== 1'b0) begin err++; $display("FAIL hold_idle_rv got %b want 0", bus.RESULT_VALID); end
    if (bus.BUSY !== 1'b0) begin err++; $display("FAIL hold_idle_busy got %b want 0", bus.BUSY); end
    fill_rand(1);
    model(1, eb, ev, es, en);
    start_run(0);
    drive(1, 0, -1, k);
    wait_rv(k, lat);
    vec += 4;
    if (lat != 4) begin err++; $display("FAIL nf0_latency got %0d want 4", lat); end
    if (bus.PEAK_BIN !== AW'(eb)) begin err++; $display("FAIL nf0_bin got %0d want %0d", bus.PEAK_BIN, eb); end
    if (bus.PEAK_VAL !== ACC_W'(ev)) begin err++; $display("FAIL nf0_val got %0d want %0d", bus.PEAK_VAL, ev); end
    if (bus.SAT_FLAG !== es) begin err++; $display("FAIL nf0_sat got %b want %b", bus.SAT_FLAG, es); end
    accept_result();
  endtask

  task automatic test_reset_midrun();
    int k, lat;
    fill_rand(3);
    start_run(3);
    drive(1, 0, -1, k);
    @(negedge clk);
    ngrst = 1'b0;
    #1;
    vec += 5;
    if (bus.BUSY !== 1'b0) begin err++; $display("FAIL mid_reset_busy got %b want 0", bus.BUSY); end
    if (bus.RESULT_VALID !== 1'b0) begin err++; $display("FAIL mid_reset_rv got %b want 0", bus.RESULT_VALID); end
    if (bus.PEAK_BIN !== '0) begin err++; $display("FAIL mid_reset_bin got %0d want 0", bus.PEAK_BIN); end
    if (bus.PEAK_VAL !== '0) begin err++; $display("FAIL mid_reset_val got %0d want 0", bus.PEAK_VAL); end
    if (bus.SAT_FLAG !== 1'b0) begin err++; $display("FAIL mid_reset_sat got %b want 0", bus.SAT_FLAG); end
    repeat (2) @(negedge clk);
    ngrst = 1'b1;
    fill_zero(1);
    for (int b = 0; b < POINTS; b++) q_re[b] = 1;
    start_run(1);
    drive(1, 0, -1, k);
    wait_rv(k, lat);
    vec += 4;
    if (lat != 4) begin err++; $display("FAIL post_reset_latency got %0d want 4", lat); end
    if (bus.PEAK_BIN !== AW'(0)) begin err++; $display("FAIL post_reset_bin got %0d want 0", bus.PEAK_BIN); end
    if (bus.PEAK_VAL !== ACC_W'(1)) begin err++; $display("FAIL post_reset_val got %0d want 1", bus.PEAK_VAL); end
    if (bus.SAT_FLAG !== 1'b0) begin err++; $display("FAIL post_reset_sat got %b want 0", bus.SAT_FLAG); end
`ifdef FFT_PEAK_NOISE_EN
    vec++;
    if (bus.NOISE_SUM !== (ACC_W+AW)'(16)) begin err++; $display("FAIL post_reset_noise got %0d want 16", bus.NOISE_SUM); end
`endif
    accept_result();
  endtask

  task automatic test_random();
    int k, lat, nfr, eb, ev, en;
    bit es;
    for (int r = 0; r < 8; r++) begin
      nfr = int'($urandom_range(1, 3));
      fill_rand(nfr);
      model(nfr, eb, ev, es, en);
      start_run(nfr);
      drive(nfr, 2, -1, k);
      wait_rv(k, lat);
      vec += 4;
      if (lat != 4) begin err++; $display("FAIL rand%0d_latency got %0d want 4", r, lat); end
      if (bus.PEAK_BIN !== AW'(eb)) begin err++; $display("FAIL rand%0d_bin got %0d want %0d", r, bus.PEAK_BIN, eb); end
      if (bus.PEAK_VAL !== ACC_W'(ev)) begin err++; $display("FAIL rand%0d_val got %0d want %0d", r, bus.PEAK_VAL, ev); end
      if (bus.SAT_FLAG !== es) begin err++; $display("FAIL rand%0d_sat got %b want %b", r, bus.SAT_FLAG, es); end
`ifdef FFT_PEAK_NOISE_EN
      vec++;
      if (bus.NOISE_SUM !== (ACC_W+AW)'(en)) begin err++; $display("FAIL rand%0d_noise got %0d want %0d", r, bus.NOISE_SUM, en); end
`endif
      accept_result();
    end
  endtask

  initial begin
    bus.START = 1'b0;
    bus.NUM_FRAMES = '0;
    bus.DATAI_RE = '0;
    bus.DATAI_IM = '0;
    bus.DATAI_VALID = 1'b0;
    bus.RESULT_READY = 1'b0;
    test_reset();
    test_single_peak();
    test_gapped_frames();
    test_tie();
    test_saturate();
    test_hold_restart();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/fft_peak_integrator.md
Name: fft_peak_integrator

Overview:
- Post-FFT non-coherent integrator for GNSS acquisition; sits directly on the FFT core output stream (DATAO_RE/DATAO_IM/DATAO_VALID).
- Computes |X|^2 per bin and accumulates it over a runtime-selectable number of frames in an internal RAM.
- On the final frame, searches inline for the peak bin and presents bin/value with a valid/ready handshake.
- Generalised in point count, sample width, accumulator width and frame count.

Parameters:
- POINTS, 1024, FFT frame length in bins; power of two, >=8.
- IN_W, 32, signed width of DATAI_RE/DATAI_IM.
- MAG_SHIFT, 32, right shift applied to re^2+im^2 before accumulation.
- ACC_W, 40, accumulator/RAM word width; unsigned, saturating.
- NF_W, 8, width of NUM_FRAMES.

Ports:
- CLK  in  1  single clock.
- NGRST  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse; arms a new integration when idle.
- NUM_FRAMES  in  NF_W  frames to integrate; sampled on an accepted START; 0 treated as 1.
- DATAI_RE  in  IN_W  FFT output, real part, signed.
- DATAI_IM  in  IN_W  FFT output, imaginary part, signed.
- DATAI_VALID  in  1  sample strobe; bins arrive in order 0..POINTS-1, gaps allowed.
- BUSY  out  1  high from an accepted START until RESULT_VALID rises.
- RESULT_VALID  out  1  peak result available; held until accepted.
- RESULT_READY  in  1  consumer accepts the result when RESULT_VALID and RESULT_READY are both high.
- PEAK_BIN  out  log2(POINTS)  index of the maximum bin.
- PEAK_VAL  out  ACC_W  accumulated value at PEAK_BIN.
- SAT_FLAG  out  1  sticky; some accumulate saturated during this run.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0. Reset mid-run aborts the run; RAM contents become don't-care.
- FSM states:
  - IDLE: START moves to INTEG; captures nf = max(NUM_FRAMES,1); clears frame_cnt, bin_cnt and SAT_FLAG; BUSY=1.
  - INTEG: each DATAI_VALID processes one bin. bin_cnt wraps POINTS-1 -> 0 and increments frame_cnt. When the last bin of frame nf-1 is processed, go to FLUSH.
  - FLUSH: wait for the 3-stage pipeline to drain, then go to DONE; RESULT_VALID=1 and BUSY=0 in the same cycle.
  - DONE: hold the outputs stable. On RESULT_VALID and RESULT_READY, drop RESULT_VALID the next cycle and return to IDLE.
- START while not in IDLE is ignored. DATAI_VALID in IDLE, FLUSH or DONE is dropped.
- Pipeline, one bin per cycle at full rate:
  - S1: register re*re and im*im (each 2*IN_W bits, unsigned); issue the RAM read for bin_cnt.
  - S2: sum = (re^2+im^2) >> MAG_SHIFT, zero-extended to ACC_W (upper bits beyond ACC_W saturate to all-ones); RAM read data valid.
  - S3: on frame 0, new = sum (RAM is not cleared beforehand); otherwise new = rd + sum, saturating at 2^ACC_W-1 and setting SAT_FLAG. Write new to the same address.
- Read/write hazard: consecutive bins have distinct addresses and a given bin recurs only after POINTS>=8 samples, so no forwarding is required.
- Peak search runs in S3 of the final frame only:
  - Bin 0 loads the running max unconditionally.
  - Later bins replace it only if new > max (strict), so ties resolve to the lowest bin.
- Latency: RESULT_VALID is asserted 4 cycles after the DATAI_VALID of the last bin of the last frame.
- RAM: simple dual-port, POINTS x ACC_W, 1-cycle read latency; inferred, no vendor primitive.

Optional Feature:
- Macro FFT_PEAK_NOISE_EN.
- When defined: extra output NOISE_SUM (ACC_W+log2(POINTS) bits) holding the sum of all final accumulated bins of the run. It is valid with RESULT_VALID, held in DONE, and reset to 0.
- When undefined: the port and its adder are absent; all other behaviour is identical.

Decomposition:
- Package fft_integ_pkg: state enum (IDLE, INTEG, FLUSH, DONE), a clog2 helper constant function, and a saturating-add function.
- One sub-module, fft_integ_ram: the parametrised dual-port accumulator RAM.

Test Plan:
- POINTS=16, NUM_FRAMES=1, bin 5 = (3,4), all other bins 0, MAG_SHIFT=0 -> PEAK_BIN=5, PEAK_VAL=25, RESULT_VALID exactly 4 cycles after bin 15, SAT_FLAG=0.
- NUM_FRAMES=4, bin 9 = (1,1) each frame, DATAI_VALID gapped randomly -> PEAK_BIN=9, PEAK_VAL=8.
- Bins 2 and 7 both = (2,0), single frame -> PEAK_BIN=2 (tie resolves to lowest bin).
- ACC_W=8, NUM_FRAMES=3, bin 1 = (10,0) -> PEAK_VAL=255, SAT_FLAG=1.
- START pulsed during INTEG, then RESULT_READY held low 10 cycles -> run unaffected, outputs stable for all 10 cycles, IDLE the cycle after acceptance; second run with NUM_FRAMES=0 behaves as 1 frame, and frame-0 overwrite makes the previous run's RAM data invisible.
- NGRST asserted mid-INTEG, then a fresh 1-frame run -> all outputs 0 during reset, correct result afterwards; with FFT_PEAK_NOISE_EN, 16 bins of (1,0) -> NOISE_SUM=16.
